// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_share_arbiter_if                                          |
// | Description : Request, arithmetic-unit and response bundle for the arbiter. |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
interface alu_share_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_a;
    logic [2:0] req0_b;
    logic [1:0] req0_op;

    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_a;
    logic [2:0] req1_b;
    logic [1:0] req1_op;

    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_sel;
    logic [5:0] alu_result;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_id;
    logic       rsp_err;

    // The arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready
    );

    // The requesters, arithmetic unit and response consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : alu_share_arbiter                                             |
// | Description : Round-robin sharing of one arithmetic unit by two requesters. |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module alu_share_arbiter #(
    parameter int ALU_WAIT   = 1,
    parameter int PRIO_RESET = 0
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_RESP    = 2'd2;
    localparam logic [2:0] c_WAIT_LAST  = 3'(ALU_WAIT);
    localparam logic       c_PRIO_RESET = 1'(PRIO_RESET);

    logic [1:0] r_state;
    logic       r_rr_ptr;
    logic [2:0] r_cnt;
    logic [2:0] r_alu_a;
    logic [2:0] r_alu_b;
    logic [1:0] r_alu_sel;
    logic       r_pend_id;
    logic       r_pend_err;
    logic       r_rsp_valid;
    logic [5:0] r_rsp_data;
    logic       r_rsp_id;
    logic       r_rsp_err;

    logic       w_idle;
    logic       w_grant_valid;
    logic       w_grant_id;
    logic       w_accept;
    logic [2:0] w_a;
    logic [2:0] w_b;
    logic [1:0] w_op;
    logic       w_div_zero;

    // Contention is settled by the round-robin pointer; a lone request always wins.
    always_comb begin
        w_grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = r_rr_ptr;
        end else if (bus.req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    assign w_idle        = (r_state == c_ST_IDLE);
    assign w_grant_valid = bus.req0_valid | bus.req1_valid;
    assign w_accept      = w_idle & w_grant_valid;
    assign w_a           = w_grant_id ? bus.req1_a  : bus.req0_a;
    assign w_b           = w_grant_id ? bus.req1_b  : bus.req0_b;
    assign w_op          = w_grant_id ? bus.req1_op : bus.req0_op;
    assign w_div_zero    = (w_op == 2'b11) && (w_b == 3'd0);

    assign bus.req0_ready = w_accept & ~w_grant_id;
    assign bus.req1_ready = w_accept &  w_grant_id;

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_err   = r_rsp_err;

    // Id and error flag stay pending until capture so the visible response fields
    // only ever change together with a new rsp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= c_PRIO_RESET;
            r_cnt       <= 3'd0;
            r_alu_a     <= 3'd0;
            r_alu_b     <= 3'd0;
            r_alu_sel   <= 2'd0;
            r_pend_id   <= 1'b0;
            r_pend_err  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 6'd0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a    <= w_a;
                        r_alu_b    <= w_b;
                        r_alu_sel  <= w_op;
                        r_pend_id  <= w_grant_id;
                        r_pend_err <= w_div_zero;
                        r_rr_ptr   <= ~w_grant_id;
                        r_cnt      <= 3'd1;
                        r_state    <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_rsp_data  <= bus.alu_result;
                        r_rsp_id    <= r_pend_id;
                        r_rsp_err   <= r_pend_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_alu_share_arbiter                                          |
// | Description : Scoreboard bench for alu_share_arbiter (two configurations).  |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tb_alu_share_arbiter;
    localparam int WAIT_A = 1;
    localparam int PRIO_A = 0;
    localparam int WAIT_B = 3;
    localparam int PRIO_B = 1;

    typedef struct {
        int data;
        int id;
        int err;
        int a;
        int b;
        int op;
        int acc;
    } exp_t;

    logic clk;
    logic rst;

    alu_share_arbiter_if bus_a();
    alu_share_arbiter_if bus_b();

    alu_share_arbiter #(.ALU_WAIT(WAIT_A), .PRIO_RESET(PRIO_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    alu_share_arbiter #(.ALU_WAIT(WAIT_B), .PRIO_RESET(PRIO_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   busy   = 0;
    int   prio   = PRIO_A;
    exp_t exp_q[$];

    // Reference arithmetic: operands are plain 0..7 integers.
    function automatic int ref_alu(input int a, input int b, input int op);
        case (op)
            0:       return a + b;
            1:       return ((a - b) % 64 + 64) % 64;
            2:       return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    assign bus_a.alu_result = 6'(ref_alu(int'(bus_a.alu_a), int'(bus_a.alu_b), int'(bus_a.alu_sel)));
    assign bus_b.alu_result = 6'(ref_alu(int'(bus_b.alu_a), int'(bus_b.alu_b), int'(bus_b.alu_sel)));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decides who should be granted and predicts the response.
    initial begin
        bit   e0;
        bit   e1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                busy = 0;
                prio = PRIO_A;
            end else begin
                e0 = 0;
                e1 = 0;
                if (!busy) begin
                    if (bus_a.req0_valid && bus_a.req1_valid) begin
                        if (prio == 0) e0 = 1; else e1 = 1;
                    end else if (bus_a.req0_valid) begin
                        e0 = 1;
                    end else if (bus_a.req1_valid) begin
                        e1 = 1;
                    end
                end
                chk("req0_ready", int'(bus_a.req0_ready), int'(e0));
                chk("req1_ready", int'(bus_a.req1_ready), int'(e1));
                if (e0 || e1) begin
                    e.id  = e1 ? 1 : 0;
                    e.a   = e1 ? int'(bus_a.req1_a)  : int'(bus_a.req0_a);
                    e.b   = e1 ? int'(bus_a.req1_b)  : int'(bus_a.req0_b);
                    e.op  = e1 ? int'(bus_a.req1_op) : int'(bus_a.req0_op);
                    e.data = ref_alu(e.a, e.b, e.op);
                    e.err = (e.op == 3 && e.b == 0) ? 1 : 0;
                    e.acc = cyc + 1;
                    exp_q.push_back(e);
                    busy = 1;
                    prio = e1 ? 0 : 1;
                end else if (busy && bus_a.rsp_valid && bus_a.rsp_ready) begin
                    busy = 0;
                end
            end
        end
    end

    // Monitor: pops on each new response and checks it is held until accepted.
    initial begin
        bit   have;
        exp_t cur;
        have = 0;
        cur  = '{default: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 0;
            end else if (bus_a.rsp_valid) begin
                if (!have) begin
                    chk("rsp_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        chk("rsp_latency", cyc - cur.acc, WAIT_A);
                        chk("alu_a", int'(bus_a.alu_a), cur.a);
                        chk("alu_b", int'(bus_a.alu_b), cur.b);
                        chk("alu_sel", int'(bus_a.alu_sel), cur.op);
                    end
                    have = 1;
                end
                chk("rsp_data", int'(bus_a.rsp_data), cur.data);
                chk("rsp_id", int'(bus_a.rsp_id), cur.id);
                chk("rsp_err", int'(bus_a.rsp_err), cur.err);
                if (bus_a.rsp_ready) have = 0;
            end
        end
    end

    // Present one operation on requester k and hold it until accepted.
    task automatic issue(input int k, input int a, input int b, input int op);
        int t;
        if (k == 0) begin
            bus_a.req0_a = 3'(a); bus_a.req0_b = 3'(b); bus_a.req0_op = 2'(op);
            bus_a.req0_valid = 1'b1;
        end else begin
            bus_a.req1_a = 3'(a); bus_a.req1_b = 3'(b); bus_a.req1_op = 2'(op);
            bus_a.req1_valid = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            t = t + 1;
        end while (!((k == 0) ? bus_a.req0_ready : bus_a.req1_ready) && t < 200);
        chk("accept_in_time", int'(t < 200), 1);
        @(posedge clk);
        #1;
        if (k == 0) bus_a.req0_valid = 1'b0;
        else        bus_a.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        chk("drain_in_time", int'(t < 200), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit done;
        int t;
        done = 0;
        rst  = 1'b1;
        bus_a.req0_valid = 1'b0; bus_a.req0_a = 3'd0; bus_a.req0_b = 3'd0; bus_a.req0_op = 2'd0;
        bus_a.req1_valid = 1'b0; bus_a.req1_a = 3'd0; bus_a.req1_b = 3'd0; bus_a.req1_op = 2'd0;
        bus_a.rsp_ready  = 1'b0;
        bus_b.req0_valid = 1'b0; bus_b.req0_a = 3'd0; bus_b.req0_b = 3'd0; bus_b.req0_op = 2'd0;
        bus_b.req1_valid = 1'b0; bus_b.req1_a = 3'd0; bus_b.req1_b = 3'd0; bus_b.req1_op = 2'd0;
        bus_b.rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_alu_a", int'(bus_a.alu_a), 0);
        chk("reset_alu_b", int'(bus_a.alu_b), 0);
        chk("reset_alu_sel", int'(bus_a.alu_sel), 0);
        chk("reset_rsp_valid", int'(bus_a.rsp_valid), 0);
        chk("reset_rsp_data", int'(bus_a.rsp_data), 0);
        chk("reset_rsp_id", int'(bus_a.rsp_id), 0);
        chk("reset_rsp_err", int'(bus_a.rsp_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_a.rsp_ready = 1'b1;

        // Single add.
        issue(0, 5, 6, 0);
        wait_idle();

        // Both requesters held valid: grants must alternate.
        do_reset();
        fork
            begin issue(0, 7, 7, 2); issue(0, 7, 7, 2); end
            begin issue(1, 2, 5, 1); issue(1, 2, 5, 1); end
        join
        wait_idle();

        // Divide by zero, then a normal divide.
        issue(1, 6, 0, 3);
        issue(1, 6, 4, 3);
        wait_idle();

        // Consumer stalls five cycles while both requesters wait.
        bus_a.rsp_ready = 1'b0;
        fork
            issue(0, 1, 2, 0);
            issue(1, 3, 3, 0);
            begin
                t = 0;
                while (!bus_a.rsp_valid && t < 50) begin
                    @(negedge clk);
                    t = t + 1;
                end
                chk("stall_rsp_seen", int'(bus_a.rsp_valid), 1);
                repeat (5) @(posedge clk);
                #1;
                bus_a.rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset while an operation is in flight.
        issue(0, 3, 2, 2);
        rst = 1'b1;
        #1;
        chk("midrst_alu_a", int'(bus_a.alu_a), 0);
        chk("midrst_alu_b", int'(bus_a.alu_b), 0);
        chk("midrst_alu_sel", int'(bus_a.alu_sel), 0);
        chk("midrst_rsp_valid", int'(bus_a.rsp_valid), 0);
        chk("midrst_rsp_data", int'(bus_a.rsp_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_rsp", int'(bus_a.rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        fork
            issue(0, 4, 4, 0);
            issue(1, 1, 1, 0);
        join
        wait_idle();

        // Random traffic with a random consumer.
        fork
            begin
                fork
                    for (int n = 0; n < 40; n++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        issue(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
                    end
                    for (int n = 0; n < 40; n++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        issue(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
                    end
                join
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                bus_a.rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus_a.rsp_ready = 1'b1;
        wait_idle();

        // Longer settle time and opposite reset priority on the second instance.
        bus_b.req0_a = 3'd2; bus_b.req0_b = 3'd3; bus_b.req0_op = 2'd2; bus_b.req0_valid = 1'b1;
        bus_b.req1_a = 3'd7; bus_b.req1_b = 3'd7; bus_b.req1_op = 2'd0; bus_b.req1_valid = 1'b1;
        @(negedge clk);
        chk("b_first_grant1", int'(bus_b.req1_ready), 1);
        chk("b_first_grant0", int'(bus_b.req0_ready), 0);
        @(posedge clk);
        #1;
        bus_b.req1_valid = 1'b0;
        t = 0;
        do begin
            @(posedge clk);
            t = t + 1;
            @(negedge clk);
            chk("b_alu_a_stable", int'(bus_b.alu_a), 7);
            chk("b_alu_b_stable", int'(bus_b.alu_b), 7);
            chk("b_alu_sel_stable", int'(bus_b.alu_sel), 0);
            chk("b_req0_ready_busy", int'(bus_b.req0_ready), 0);
        end while (!bus_b.rsp_valid && t < 20);
        chk("b_latency", t, WAIT_B);
        chk("b_rsp_data", int'(bus_b.rsp_data), ref_alu(7, 7, 0));
        chk("b_rsp_id", int'(bus_b.rsp_id), 1);
        chk("b_rsp_err", int'(bus_b.rsp_err), 0);
        @(posedge clk);
        @(negedge clk);
        chk("b_second_grant0", int'(bus_b.req0_ready), 1);
        @(posedge clk);
        #1;
        bus_b.req0_valid = 1'b0;
        t = 0;
        while (!bus_b.rsp_valid && t < 20) begin
            @(negedge clk);
            t = t + 1;
        end
        chk("b_rsp2_data", int'(bus_b.rsp_data), ref_alu(2, 3, 2));
        chk("b_rsp2_id", int'(bus_b.rsp_id), 0);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
